// File: rtl/sort_core.sv
// sort_core: sorts NBLK two-key blocks held in an external DRAM.
//
// Three stages run in sequence after reset:
//   init    - writes blocks 0..NBLK-1 with a generated key pattern
//   sort    - N = 2*NBLK passes of odd-even transposition sort, moving one
//             block per DRAM transaction
//   readout - reads every block in order and streams its two keys on
//             F01_deq0/F01_deq1 with F01_dot0/F01_dot1, flagging ERROR if
//             the stream ever decreases
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   initdone   sticky, init stage complete
//   sortdone   sticky, readout stage complete
//   ERROR      sticky, readout stream went down at least once
//   d_busy     DRAM controller is executing a request
//   d_din      write data block {key1, key0}
//   d_w        DRAM consumes the write block this cycle
//   d_dout     read data block {key1, key0}
//   d_douten   d_dout valid strobe
//   d_req      2'b01 read, 2'b10 write, one-cycle pulse
//   d_initadr  byte address of the requested block
//   d_blocks   block count of the request (always 1)

module sort_core #(
  parameter int          DRAMW    = 64,
  parameter int          NBLK     = 8,
  parameter string       INITTYPE = "reverse",
  parameter logic [31:0] BASEADR  = 32'd0
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             initdone,
  output logic             sortdone,
  input  logic             d_busy,
  output logic [DRAMW-1:0] d_din,
  input  logic             d_w,
  input  logic [DRAMW-1:0] d_dout,
  input  logic             d_douten,
  output logic [1:0]       d_req,
  output logic [31:0]      d_initadr,
  output logic [31:0]      d_blocks,
  output logic             ERROR
);

  localparam int N  = 2 * NBLK;
  localparam int BW = $clog2(NBLK);
  localparam int PW = $clog2(N);

  localparam logic [BW-1:0] LAST_BLK   = BW'(NBLK - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);
  localparam logic [31:0]   XS_SEED    = 32'd2463534242;

  localparam logic [1:0] MODE = (INITTYPE == "sorted")   ? 2'd1 :
                                (INITTYPE == "xorshift") ? 2'd2 : 2'd0;

  localparam logic [1:0] REQ_RD = 2'b01;
  localparam logic [1:0] REQ_WR = 2'b10;

  typedef enum logic [3:0] {
    INIT_REQ,
    INIT_WAIT,
    PASS_RD_REQ,
    PASS_RD_WAIT,
    PASS_WR_REQ,
    PASS_WR_WAIT,
    OUT_RD_REQ,
    OUT_RD_WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [BW-1:0]   blk;
  logic [BW-1:0]   wr_blk;
  logic [PW-1:0]   phase_a;
  logic [PW-1:0]   phase_b;
  logic            pchange_a;
  logic            pchange_b;
  logic            last_phase;
  logic            seen;
  logic            loaded;
  logic [31:0]     xs_state;
  logic [31:0]     hold_k0;
  logic [31:0]     hold_k1;
  logic [31:0]     prev_key;
  logic            have_prev;
  logic            F01_deq0;
  logic            F01_deq1;
  logic [31:0]     F01_dot0;
  logic [31:0]     F01_dot1;

  logic [31:0]     rd_k0;
  logic [31:0]     rd_k1;
  logic [31:0]     blk_ext;
  logic [31:0]     xs_a;
  logic [31:0]     xs_b;
  logic [31:0]     init_k0;
  logic [31:0]     init_k1;
  logic            wr_done;

  assign phase_b   = phase_a;
  assign pchange_b = pchange_a;

  assign rd_k0 = d_dout[31:0];
  assign rd_k1 = d_dout[63:32];

  // A write is finished once the controller has shown activity (busy or the
  // write strobe) and busy has dropped again.
  assign wr_done = seen & ~d_busy;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [DRAMW-1:0] pack(input logic [31:0] k0, input logic [31:0] k1);
    logic [DRAMW-1:0] b;
    b = '0;
    b[63:0] = {k1, k0};
    return b;
  endfunction

  function automatic logic [31:0] adr_of(input logic [BW-1:0] b);
    return BASEADR + (32'(b) << 3);
  endfunction

  // Key pair for the init block currently addressed by blk. Key index i lives
  // in block i/2, so block blk holds indices 2*blk and 2*blk+1.
  always_comb begin
    blk_ext = 32'(blk);
    xs_a    = xorshift32(xs_state);
    xs_b    = xorshift32(xs_a);
    case (MODE)
      2'd1: begin
        init_k0 = (blk_ext << 1) + 32'd1;
        init_k1 = (blk_ext << 1) + 32'd2;
      end
      2'd2: begin
        init_k0 = xs_a;
        init_k1 = xs_b;
      end
      default: begin
        init_k0 = 32'(N) - (blk_ext << 1);
        init_k1 = 32'(N) - (blk_ext << 1) - 32'd1;
      end
    endcase
  end

  // Main sequencer. Every DRAM request is a one-cycle pulse issued only while
  // the controller is idle; the matching WAIT state holds until that single
  // transaction has completed. During odd passes hold_k0/hold_k1 carry the
  // block that has been read but not yet written back, so each boundary
  // compare sees the upper neighbour before the lower block is committed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= INIT_REQ;
      blk        <= '0;
      wr_blk     <= '0;
      phase_a    <= '0;
      pchange_a  <= 1'b0;
      last_phase <= 1'b0;
      seen       <= 1'b0;
      loaded     <= 1'b0;
      xs_state   <= XS_SEED;
      hold_k0    <= '0;
      hold_k1    <= '0;
      prev_key   <= '0;
      have_prev  <= 1'b0;
      F01_deq0   <= 1'b0;
      F01_deq1   <= 1'b0;
      F01_dot0   <= '0;
      F01_dot1   <= '0;
      d_req      <= 2'b00;
      d_din      <= '0;
      d_initadr  <= '0;
      d_blocks   <= '0;
      initdone   <= 1'b0;
      sortdone   <= 1'b0;
      ERROR      <= 1'b0;
    end else begin
      d_req     <= 2'b00;
      pchange_a <= 1'b0;
      F01_deq0  <= 1'b0;
      F01_deq1  <= 1'b0;

      // Sortedness check on the keys streamed last cycle: key0 against the
      // previous stream key, then key1 against key0.
      if (last_phase && F01_deq0 && F01_deq1) begin
        if ((have_prev && (F01_dot0 < prev_key)) || (F01_dot1 < F01_dot0))
          ERROR <= 1'b1;
        prev_key  <= F01_dot1;
        have_prev <= 1'b1;
      end

      case (state)
        // Data is loaded one cycle before the request so it is stable ahead
        // of the strobe.
        INIT_REQ: begin
          if (!loaded) begin
            d_din     <= pack(init_k0, init_k1);
            d_initadr <= adr_of(blk);
            xs_state  <= xs_b;
            loaded    <= 1'b1;
          end else if (!d_busy) begin
            d_req    <= REQ_WR;
            d_blocks <= 32'd1;
            seen     <= 1'b0;
            loaded   <= 1'b0;
            state    <= INIT_WAIT;
          end
        end

        INIT_WAIT: begin
          if (wr_done) begin
            if (blk == LAST_BLK) begin
              initdone  <= 1'b1;
              phase_a   <= '0;
              pchange_a <= 1'b1;
              state     <= PASS_RD_REQ;
            end else begin
              blk   <= blk + BW'(1);
              state <= INIT_REQ;
            end
          end else begin
            seen <= seen | d_busy | d_w;
          end
        end

        // The pass-start pulse cycle rewinds the block pointer; the first
        // read of the pass goes out on the following cycle.
        PASS_RD_REQ: begin
          if (pchange_b) begin
            blk <= '0;
          end else if (!d_busy) begin
            d_req     <= REQ_RD;
            d_initadr <= adr_of(blk);
            d_blocks  <= 32'd1;
            state     <= PASS_RD_WAIT;
          end
        end

        PASS_RD_WAIT: begin
          if (d_douten) begin
            if (!phase_a[0]) begin
              d_din  <= (rd_k0 > rd_k1) ? pack(rd_k1, rd_k0) : pack(rd_k0, rd_k1);
              wr_blk <= blk;
              state  <= PASS_WR_REQ;
            end else if (blk == '0) begin
              hold_k0 <= rd_k0;
              hold_k1 <= rd_k1;
              blk     <= BW'(1);
              state   <= PASS_RD_REQ;
            end else begin
              if (hold_k1 > rd_k0) begin
                d_din   <= pack(hold_k0, rd_k0);
                hold_k0 <= hold_k1;
              end else begin
                d_din   <= pack(hold_k0, hold_k1);
                hold_k0 <= rd_k0;
              end
              hold_k1 <= rd_k1;
              wr_blk  <= blk - BW'(1);
              state   <= PASS_WR_REQ;
            end
          end
        end

        PASS_WR_REQ: begin
          if (!d_busy) begin
            d_req     <= REQ_WR;
            d_initadr <= adr_of(wr_blk);
            d_blocks  <= 32'd1;
            seen      <= 1'b0;
            state     <= PASS_WR_WAIT;
          end
        end

        // After the final odd-pass read, the held top block still needs its
        // own write-back before the pass can end.
        PASS_WR_WAIT: begin
          if (wr_done) begin
            if (wr_blk == LAST_BLK) begin
              if (phase_b == LAST_PHASE) begin
                last_phase <= 1'b1;
                blk        <= '0;
                state      <= OUT_RD_REQ;
              end else begin
                phase_a   <= phase_a + PW'(1);
                pchange_a <= 1'b1;
                state     <= PASS_RD_REQ;
              end
            end else if (phase_a[0] && (blk == LAST_BLK)) begin
              d_din  <= pack(hold_k0, hold_k1);
              wr_blk <= LAST_BLK;
              state  <= PASS_WR_REQ;
            end else begin
              blk   <= blk + BW'(1);
              state <= PASS_RD_REQ;
            end
          end else begin
            seen <= seen | d_busy | d_w;
          end
        end

        OUT_RD_REQ: begin
          if (!d_busy) begin
            d_req     <= REQ_RD;
            d_initadr <= adr_of(blk);
            d_blocks  <= 32'd1;
            state     <= OUT_RD_WAIT;
          end
        end

        OUT_RD_WAIT: begin
          if (d_douten) begin
            F01_deq0 <= 1'b1;
            F01_deq1 <= 1'b1;
            F01_dot0 <= rd_k0;
            F01_dot1 <= rd_k1;
            if (blk == LAST_BLK) begin
              sortdone <= 1'b1;
              state    <= DONE;
            end else begin
              blk   <= blk + BW'(1);
              state <= OUT_RD_REQ;
            end
          end
        end

        default: begin
          state <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_core.sv
// tb_sort_core: directed bench for sort_core.
//
// Three cores run side by side, each against its own one-block-per-request
// DRAM model: "reverse" with 8 blocks, "sorted" with 8 blocks and
// "xorshift" with 4 blocks. The reverse core is later rerun with busy
// stretched by 5 cycles, reset in the middle of pass 5 and run again to
// completion. Per-core monitors log init writes, streamed keys and pass
// starts, and count protocol violations.

module tb_sort_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [3] = '{1'b0, 1'b0, 1'b0};
  int   stretch [3] = '{0, 0, 0};

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  localparam int LIMIT = 30000;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int    NB = (g == 2) ? 4 : 8;
    localparam string IT = (g == 0) ? "reverse" : ((g == 1) ? "sorted" : "xorshift");

    logic        initdone;
    logic        sortdone;
    logic        err;
    logic        busy   = 1'b0;
    logic        douten = 1'b0;
    logic        dw     = 1'b0;
    logic [63:0] din;
    logic [63:0] dout   = '0;
    logic [1:0]  req;
    logic [31:0] initadr;
    logic [31:0] blocks;

    sort_core #(
      .DRAMW(64),
      .NBLK(NB),
      .INITTYPE(IT),
      .BASEADR(32'd0)
    ) dut (
      .CLK(clk),
      .RST(rst_n[g]),
      .initdone(initdone),
      .sortdone(sortdone),
      .d_busy(busy),
      .d_din(din),
      .d_w(dw),
      .d_dout(dout),
      .d_douten(douten),
      .d_req(req),
      .d_initadr(initadr),
      .d_blocks(blocks),
      .ERROR(err)
    );

    logic [63:0] mem [8];
    int          cnt     = 0;
    logic        is_rd   = 1'b0;
    logic [31:0] adr     = '0;
    logic [63:0] din_req = '0;

    int dup_err  = 0;
    int busy_err = 0;
    int blk_err  = 0;
    int hold_err = 0;
    int chg_err  = 0;

    int          out_n = 0;
    int          iw_n  = 0;
    int          pc_n  = 0;
    int          last_pc_phase = 0;
    logic [31:0] out_k  [64];
    logic [31:0] iw_adr [64];
    logic [63:0] iw_dat [64];

    // DRAM model: busy rises the cycle after a request, stays up for
    // 1+stretch cycles, and the read data / write commit lands as busy falls.
    // The controller is reset together with the core.
    always @(posedge clk) begin
      douten <= 1'b0;
      dw     <= 1'b0;
      if (!rst_n[g]) begin
        busy <= 1'b0;
      end else if (busy) begin
        if (req != 2'b00) dup_err <= dup_err + 1;
        if (cnt == 0) begin
          busy <= 1'b0;
          if (is_rd) begin
            douten <= 1'b1;
            dout   <= mem[adr[5:3]];
          end else begin
            dw <= 1'b1;
            mem[adr[5:3]] <= din;
            if (din !== din_req) hold_err <= hold_err + 1;
          end
        end else begin
          cnt <= cnt - 1;
        end
      end else if (req != 2'b00) begin
        busy    <= 1'b1;
        cnt     <= stretch[g];
        is_rd   <= (req == 2'b01);
        adr     <= initadr;
        din_req <= din;
        if (blocks != 32'd1 || req == 2'b11) blk_err <= blk_err + 1;
      end
    end

    // Monitors sampled away from the active edge.
    always @(negedge clk) begin
      int bad;
      bad = 0;
      if (req != 2'b00 && busy) busy_err <= busy_err + 1;
      if (req == 2'b10 && !initdone) begin
        if (iw_n < 64) begin
          iw_adr[iw_n] <= initadr;
          iw_dat[iw_n] <= din;
        end
        iw_n <= iw_n + 1;
      end
      if (dut.F01_deq0) begin
        if (out_n < 63) begin
          out_k[out_n]     <= dut.F01_dot0;
          out_k[out_n + 1] <= dut.F01_dot1;
        end
        out_n <= out_n + 2;
      end
      if (dut.pchange_a) begin
        pc_n          <= pc_n + 1;
        last_pc_phase <= int'(dut.phase_a);
        if (g == 1) begin
          for (int k = 0; k < NB; k++)
            if (mem[k] !== {32'(2 * k + 2), 32'(2 * k + 1)}) bad++;
          chg_err <= chg_err + bad;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds core idx in reset for two cycles with a new busy stretch applied.
  task automatic applyStimulus(input int idx, input int str);
    rst_n[idx]   = 1'b0;
    stretch[idx] = str;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    int base_iw;
    int base_out;
    int base_pc;
    logic [31:0] xs_sorted [8];

    // First eight xorshift32 outputs from seed 2463534242, ascending.
    xs_sorted = '{32'd374114282, 32'd691148861, 32'd723471715, 32'd1350636274,
                  32'd2008045182, 32'd2064144800, 32'd2497366906, 32'd3532304609};

    repeat (3) @(negedge clk);
    checkOutput("rst_req",      g_inst[0].req,      64'd0);
    checkOutput("rst_din",      g_inst[0].din,      64'd0);
    checkOutput("rst_initadr",  g_inst[0].initadr,  64'd0);
    checkOutput("rst_blocks",   g_inst[0].blocks,   64'd0);
    checkOutput("rst_initdone", g_inst[0].initdone, 64'd0);
    checkOutput("rst_sortdone", g_inst[0].sortdone, 64'd0);
    checkOutput("rst_error",    g_inst[0].err,      64'd0);

    rst_n = '{1'b1, 1'b1, 1'b1};
    cyc = 0;
    while (!(g_inst[0].sortdone && g_inst[1].sortdone && g_inst[2].sortdone) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);

    // Reverse pattern, 8 blocks, no stretch.
    checkOutput("rev_sortdone", g_inst[0].sortdone, 64'd1);
    checkOutput("rev_initdone", g_inst[0].initdone, 64'd1);
    checkOutput("rev_init_wr_count", g_inst[0].iw_n, 64'd8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("rev_init_adr%0d", i), g_inst[0].iw_adr[i], 64'(8 * i));
    checkOutput("rev_block0", g_inst[0].iw_dat[0], {32'd15, 32'd16});
    checkOutput("rev_block7", g_inst[0].iw_dat[7], {32'd1, 32'd2});
    checkOutput("rev_passes", g_inst[0].pc_n, 64'd16);
    checkOutput("rev_last_phase", g_inst[0].last_pc_phase, 64'd15);
    checkOutput("rev_out_count", g_inst[0].out_n, 64'd16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("rev_out%0d", i), g_inst[0].out_k[i], 64'(i + 1));
    checkOutput("rev_error", g_inst[0].err, 64'd0);
    checkOutput("rev_idle_req", g_inst[0].req, 64'd0);

    // Sorted pattern: never swaps.
    checkOutput("srt_sortdone", g_inst[1].sortdone, 64'd1);
    checkOutput("srt_passes", g_inst[1].pc_n, 64'd16);
    checkOutput("srt_mem_changed", g_inst[1].chg_err, 64'd0);
    checkOutput("srt_out_count", g_inst[1].out_n, 64'd16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("srt_out%0d", i), g_inst[1].out_k[i], 64'(i + 1));
    checkOutput("srt_error", g_inst[1].err, 64'd0);

    // Xorshift pattern, 4 blocks.
    checkOutput("xs_sortdone", g_inst[2].sortdone, 64'd1);
    checkOutput("xs_passes", g_inst[2].pc_n, 64'd8);
    checkOutput("xs_out_count", g_inst[2].out_n, 64'd8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("xs_out%0d", i), g_inst[2].out_k[i], 64'(xs_sorted[i]));
    checkOutput("xs_error", g_inst[2].err, 64'd0);

    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("dup_req%0d", g),
                  (g == 0) ? g_inst[0].dup_err : ((g == 1) ? g_inst[1].dup_err : g_inst[2].dup_err), 64'd0);
      checkOutput($sformatf("req_busy%0d", g),
                  (g == 0) ? g_inst[0].busy_err : ((g == 1) ? g_inst[1].busy_err : g_inst[2].busy_err), 64'd0);
      checkOutput($sformatf("blocks%0d", g),
                  (g == 0) ? g_inst[0].blk_err : ((g == 1) ? g_inst[1].blk_err : g_inst[2].blk_err), 64'd0);
      checkOutput($sformatf("din_hold%0d", g),
                  (g == 0) ? g_inst[0].hold_err : ((g == 1) ? g_inst[1].hold_err : g_inst[2].hold_err), 64'd0);
    end

    // Reverse core again with busy stretched, reset during pass 5.
    applyStimulus(0, 5);
    base_pc = g_inst[0].pc_n;
    rst_n[0] = 1'b1;
    cyc = 0;
    while (!(g_inst[0].initdone && g_inst[0].dut.phase_a == 5) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("mid_reached_pass5", 64'(g_inst[0].dut.phase_a), 64'd5);
    repeat (7) @(negedge clk);
    checkOutput("mid_passes_started", g_inst[0].pc_n - base_pc, 64'd6);
    rst_n[0] = 1'b0;
    #1;
    checkOutput("mid_rst_req",      g_inst[0].req,      64'd0);
    checkOutput("mid_rst_din",      g_inst[0].din,      64'd0);
    checkOutput("mid_rst_initadr",  g_inst[0].initadr,  64'd0);
    checkOutput("mid_rst_blocks",   g_inst[0].blocks,   64'd0);
    checkOutput("mid_rst_initdone", g_inst[0].initdone, 64'd0);
    checkOutput("mid_rst_sortdone", g_inst[0].sortdone, 64'd0);
    checkOutput("mid_rst_error",    g_inst[0].err,      64'd0);
    checkOutput("mid_rst_phase",    64'(g_inst[0].dut.phase_a), 64'd0);
    repeat (2) @(negedge clk);
    base_iw  = g_inst[0].iw_n;
    base_out = g_inst[0].out_n;
    base_pc  = g_inst[0].pc_n;
    rst_n[0] = 1'b1;
    cyc = 0;
    while (!g_inst[0].sortdone && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);

    checkOutput("str_sortdone", g_inst[0].sortdone, 64'd1);
    checkOutput("str_init_wr_count", g_inst[0].iw_n - base_iw, 64'd8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("str_init_adr%0d", i), g_inst[0].iw_adr[base_iw + i], 64'(8 * i));
    checkOutput("str_block0", g_inst[0].iw_dat[base_iw], {32'd15, 32'd16});
    checkOutput("str_block7", g_inst[0].iw_dat[base_iw + 7], {32'd1, 32'd2});
    checkOutput("str_passes", g_inst[0].pc_n - base_pc, 64'd16);
    checkOutput("str_out_count", g_inst[0].out_n - base_out, 64'd16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("str_out%0d", i), g_inst[0].out_k[base_out + i], 64'(i + 1));
    checkOutput("str_error",    g_inst[0].err,      64'd0);
    checkOutput("str_dup_req",  g_inst[0].dup_err,  64'd0);
    checkOutput("str_req_busy", g_inst[0].busy_err, 64'd0);
    checkOutput("str_blocks",   g_inst[0].blk_err,  64'd0);
    checkOutput("str_din_hold", g_inst[0].hold_err, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
